// File: rtl/boot_loader.sv
// Boot block: copies a parameter-held boot image into instruction memory
// over a ready-handshaked write port, holding the CPU until the copy is done.
module boot_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 26,
  parameter int IMAGE_SIZE = 18,
  parameter int COPY_COUNT = 18,
  parameter logic [ADDR_WIDTH-1:0] DEST_BASE = '0,
  // Word 0 of the image occupies the most significant slot.
  parameter logic [IMAGE_SIZE*DATA_WIDTH-1:0] IMAGE_INIT = {
    32'h3C1D0000, 32'h37BD0400, 32'h3C080000, 32'h35080100,
    32'h3C090000, 32'h35290200, 32'h8D0A0000, 32'hAD2A0000,
    32'h21080004, 32'h21290004, 32'h2084FFFF, 32'h1480FFFA,
    32'h00000000, 32'h3C0B1000, 32'hAD600000, 32'h00000000,
    32'h00000000, 32'hFC000000
  },
  localparam int CW = $clog2(COPY_COUNT + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic [CW-1:0]         word_count,
  output logic [DATA_WIDTH-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] L_LAST_IDX = CW'(COPY_COUNT - 1);

  state_t                r_state;
  logic [CW-1:0]         r_idx;
  logic [CW-1:0]         r_word_count;
  logic [DATA_WIDTH-1:0] r_checksum;
  logic                  r_mem_we;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_cpu_hold;

  logic [DATA_WIDTH-1:0] w_rom_word;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_load;

  // Indices past the image fall through to the last word (HALT padding).
  always_comb begin
    w_rom_word = IMAGE_INIT[0 +: DATA_WIDTH];
    for (int k = 0; k < IMAGE_SIZE; k++) begin
      if (32'(r_idx) == k)
        w_rom_word = IMAGE_INIT[(IMAGE_SIZE-1-k)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_addr = DEST_BASE + ADDR_WIDTH'(r_idx);
  assign w_load = (r_state == LOAD);

  assign mem_addr   = w_load ? w_addr : '0;
  assign mem_data   = w_load ? w_rom_word : '0;
  assign mem_we     = r_mem_we;
  assign busy       = r_busy;
  assign done       = r_done;
  assign cpu_hold   = r_cpu_hold;
  assign word_count = r_word_count;
  assign checksum   = r_checksum;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_word_count <= '0;
      r_checksum   <= '0;
      r_mem_we     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cpu_hold   <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_state      <= LOAD;
          r_idx        <= '0;
          r_word_count <= '0;
          r_checksum   <= '0;
          r_mem_we     <= 1'b1;
          r_busy       <= 1'b1;
          r_done       <= 1'b0;
          r_cpu_hold   <= 1'b1;
        end
        LOAD: begin
          if (mem_ready) begin
            r_checksum   <= r_checksum ^ w_rom_word;
            r_word_count <= r_word_count + CW'(1);
            r_idx        <= r_idx + CW'(1);
            if (r_idx == L_LAST_IDX) begin
              r_state    <= DONE;
              r_mem_we   <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end
          end
        end
        DONE: begin
          if (start) begin
            r_state      <= LOAD;
            r_idx        <= '0;
            r_word_count <= '0;
            r_checksum   <= '0;
            r_mem_we     <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_cpu_hold   <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_mem_we   <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_cpu_hold <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: three builds (tiny, default, wrapping base)
// checked every cycle against a write-sequence reference model.
module tb_boot_loader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset = 1'b1;
  logic start = 1'b0;
  logic rdy [3];

  logic        a_we, b_we, c_we;
  logic [25:0] a_addr, b_addr, c_addr;
  logic [31:0] a_data, b_data, c_data;
  logic        a_hold, b_hold, c_hold;
  logic        a_busy, b_busy, c_busy;
  logic        a_done, b_done, c_done;
  logic [2:0]  a_wc, c_wc;
  logic [4:0]  b_wc;
  logic [31:0] a_cs, b_cs, c_cs;

  boot_loader #(
    .IMAGE_SIZE(3), .COPY_COUNT(4), .DEST_BASE(26'h100),
    .IMAGE_INIT({32'h11111111, 32'h22222222, 32'h33333333})
  ) u_a (
    .clock(clock), .reset(reset), .start(start), .mem_ready(rdy[0]),
    .mem_we(a_we), .mem_addr(a_addr), .mem_data(a_data),
    .cpu_hold(a_hold), .busy(a_busy), .done(a_done),
    .word_count(a_wc), .checksum(a_cs)
  );

  boot_loader u_b (
    .clock(clock), .reset(reset), .start(start), .mem_ready(rdy[1]),
    .mem_we(b_we), .mem_addr(b_addr), .mem_data(b_data),
    .cpu_hold(b_hold), .busy(b_busy), .done(b_done),
    .word_count(b_wc), .checksum(b_cs)
  );

  boot_loader #(
    .IMAGE_SIZE(3), .COPY_COUNT(4), .DEST_BASE(26'h3FFFFFE),
    .IMAGE_INIT({32'h11111111, 32'h22222222, 32'h33333333})
  ) u_c (
    .clock(clock), .reset(reset), .start(start), .mem_ready(rdy[2]),
    .mem_we(c_we), .mem_addr(c_addr), .mem_data(c_data),
    .cpu_hold(c_hold), .busy(c_busy), .done(c_done),
    .word_count(c_wc), .checksum(c_cs)
  );

  logic        o_we [3], o_hold [3], o_busy [3], o_done [3];
  logic [25:0] o_addr [3];
  logic [31:0] o_data [3], o_cs [3];
  logic [7:0]  o_wc [3];

  assign o_we   = '{a_we, b_we, c_we};
  assign o_hold = '{a_hold, b_hold, c_hold};
  assign o_busy = '{a_busy, b_busy, c_busy};
  assign o_done = '{a_done, b_done, c_done};
  assign o_addr = '{a_addr, b_addr, c_addr};
  assign o_data = '{a_data, b_data, c_data};
  assign o_cs   = '{a_cs, b_cs, c_cs};
  assign o_wc   = '{8'(a_wc), 8'(b_wc), 8'(c_wc)};

  logic [31:0] timg [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
  logic [31:0] dimg [18] = '{
    32'h3C1D0000, 32'h37BD0400, 32'h3C080000, 32'h35080100,
    32'h3C090000, 32'h35290200, 32'h8D0A0000, 32'hAD2A0000,
    32'h21080004, 32'h21290004, 32'h2084FFFF, 32'h1480FFFA,
    32'h00000000, 32'h3C0B1000, 32'hAD600000, 32'h00000000,
    32'h00000000, 32'hFC000000};
  int          cfg_cc [3] = '{4, 18, 4};
  logic [25:0] cfg_base [3] = '{26'h100, 26'h0, 26'h3FFFFFE};
  logic [25:0] wrap_exp [4] = '{26'h3FFFFFE, 26'h3FFFFFF, 26'h0, 26'h1};

  // Reference: phase 0 = before auto-boot, 1 = copying, 2 = finished.
  int          m_ph [3];
  int          m_k [3];
  logic [31:0] m_sum [3];

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] exp_data(int i, int k);
    if (i == 1) return dimg[(k > 17) ? 17 : k];
    return timg[(k > 2) ? 2 : k];
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_ph[i] = 0; m_k[i] = 0; m_sum[i] = '0;
      end else if (m_ph[i] == 0) begin
        m_ph[i] = 1; m_k[i] = 0; m_sum[i] = '0;
      end else if (m_ph[i] == 1) begin
        if (rdy[i]) begin
          m_sum[i] = m_sum[i] ^ exp_data(i, m_k[i]);
          m_k[i]++;
          if (m_k[i] == cfg_cc[i]) m_ph[i] = 2;
        end
      end else if (start) begin
        m_ph[i] = 1; m_k[i] = 0; m_sum[i] = '0;
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("i%0d_we", i), 64'(o_we[i]), 64'(m_ph[i] == 1));
      chk($sformatf("i%0d_busy", i), 64'(o_busy[i]), 64'(m_ph[i] == 1));
      chk($sformatf("i%0d_done", i), 64'(o_done[i]), 64'(m_ph[i] == 2));
      chk($sformatf("i%0d_hold", i), 64'(o_hold[i]), 64'(m_ph[i] != 2));
      chk($sformatf("i%0d_wc", i), 64'(o_wc[i]), 64'(m_k[i]));
      chk($sformatf("i%0d_cs", i), 64'(o_cs[i]), 64'(m_sum[i]));
      if (m_ph[i] == 1) begin
        chk($sformatf("i%0d_addr", i), 64'(o_addr[i]),
            64'(26'(cfg_base[i] + 26'(m_k[i]))));
        chk($sformatf("i%0d_data", i), 64'(o_data[i]),
            64'(exp_data(i, m_k[i])));
      end
    end
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (n < 100 && !(a_done && b_done && c_done)) begin
      tick();
      n++;
    end
    chk("settle_all_done", 64'(a_done && b_done && c_done), 64'd1);
  endtask

  initial begin
    logic [31:0] dsum;
    rdy = '{1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      m_ph[i] = 0; m_k[i] = 0; m_sum[i] = '0;
    end
    dsum = '0;
    for (int k = 0; k < 18; k++) dsum ^= dimg[k];

    tick();
    tick();
    chk("rst_hold", 64'(a_hold), 64'd1);
    chk("rst_we", 64'(b_we), 64'd0);
    reset = 1'b0;

    // Auto-boot latency and wrapping addresses
    for (int e = 0; e < 19; e++) begin
      tick();
      if (e < 4) chk($sformatf("wrap_addr%0d", e), 64'(c_addr),
                     64'(wrap_exp[e]));
      if (e == 3) chk("tiny_done_early", 64'(a_done), 64'd0);
      if (e == 4) chk("tiny_done_lat", 64'(a_done), 64'd1);
      if (e == 17) chk("dflt_done_early", 64'(b_done), 64'd0);
    end
    chk("dflt_done_lat", 64'(b_done), 64'd1);
    chk("dflt_wc", 64'(b_wc), 64'd18);
    chk("dflt_cs", 64'(b_cs), 64'(dsum));
    chk("tiny_wc", 64'(a_wc), 64'd4);
    chk("tiny_cs", 64'(a_cs), 64'h33333333);

    // Reboot with a 3-cycle stall on tiny word 1
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rdy[0] = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stall_addr", 64'(a_addr), 64'h101);
      chk("stall_data", 64'(a_data), 64'h22222222);
      chk("stall_we", 64'(a_we), 64'd1);
      chk("stall_wc", 64'(a_wc), 64'd1);
    end
    rdy[0] = 1'b1;
    tick();
    tick();
    chk("stall_not_done", 64'(a_done), 64'd0);
    tick();
    chk("stall_done", 64'(a_done), 64'd1);
    chk("stall_cs", 64'(a_cs), 64'h33333333);
    // start while default build is still copying
    chk("dflt_in_load", 64'(b_busy), 64'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    settle();
    chk("dflt_recopy_wc", 64'(b_wc), 64'd18);
    chk("dflt_recopy_cs", 64'(b_cs), 64'(dsum));

    // Reset while tiny presents word 2
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_rst_addr", 64'(a_addr), 64'h102);
    reset = 1'b1;
    tick();
    chk("mid_rst_we", 64'(a_we), 64'd0);
    chk("mid_rst_hold", 64'(a_hold), 64'd1);
    chk("mid_rst_cs", 64'(a_cs), 64'd0);
    reset = 1'b0;
    tick();
    chk("restart_addr", 64'(a_addr), 64'h100);
    settle();

    // Random handshake, start and reset traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 3; i++) rdy[i] = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 11) == 0);
      reset = ($urandom_range(0, 79) == 0);
      tick();
    end
    start = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Memory never ready
    rdy = '{1'b0, 1'b0, 1'b0};
    for (int n = 0; n < 40; n++) tick();
    chk("stuck_busy", 64'(a_busy), 64'd1);
    chk("stuck_hold", 64'(b_hold), 64'd1);
    chk("stuck_done", 64'(b_done), 64'd0);
    chk("stuck_wc", 64'(a_wc), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
